// File: rtl/cam_match_encoder.sv
// Turns a multi-hot CAM match vector into a stream of binary row indices, lowest row first.
// A vector is captured only in IDLE; ITER walks the pending bits one handshake at a time.
//
// state | meaning
// IDLE  | ready for a new match_vector, no output pending
// ITER  | presenting the lowest remaining pending row on out_addr
module cam_match_encoder #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  match_valid,
  input  logic [CAM_DEPTH-1:0]  match_vector,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic [ADDR_WIDTH:0]   match_count,
  output logic                  no_match
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ITER = 1'b1;

  logic [0:0]            state;
  logic [CAM_DEPTH-1:0]  pending;
  logic [CAM_DEPTH-1:0]  pending_cleared;
  logic [ADDR_WIDTH-1:0] addr_enc;
  logic                  one_left;

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [CAM_DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      cnt = cnt + (ADDR_WIDTH+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Highest-to-lowest scan so the lowest set row wins.
  always_comb begin
    addr_enc = '0;
    for (int i = CAM_DEPTH-1; i >= 0; i--) begin
      if (pending[i]) addr_enc = ADDR_WIDTH'(i);
    end
  end

  // x & (x-1) drops the lowest set bit; a zero result means only one bit was left.
  assign pending_cleared = pending & (pending - CAM_DEPTH'(1));
  assign one_left        = (pending != '0) && (pending_cleared == '0);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_ITER);
  assign out_addr  = addr_enc;
  assign out_last  = (state == S_ITER) && one_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pending     <= '0;
      match_count <= '0;
      no_match    <= 1'b0;
    end else begin
      no_match <= 1'b0;
      case (state)
        S_IDLE: begin
          if (match_valid) begin
            pending     <= match_vector;
            match_count <= popcount(match_vector);
            if (match_vector != '0) state <= S_ITER;
            else                    no_match <= 1'b1;
          end
        end
        S_ITER: begin
          if (out_ready) begin
            pending <= pending_cleared;
            if (one_left) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam_match_encoder.md
CAM_MATCH_ENCODER -- requirements
Module: cam_match_encoder

Interface
REQ-001 Parameter: CAM_DEPTH, default 8, number of CAM rows (width of the match vector); legal range 2..64.
REQ-002 Parameter: ADDR_WIDTH, default 3, encoded address width; SHALL equal ceil(log2(CAM_DEPTH)).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: match_valid  input  1  match_vector is valid this cycle.
REQ-006 Port: match_vector  input  CAM_DEPTH  multi-hot decoded match address from the CAM stage; bit i set = row i matched.
REQ-007 Port: in_ready  output  1  block can accept a new match_vector.
REQ-008 Port: out_valid  output  1  out_addr holds a valid matching row index.
REQ-009 Port: out_ready  input  1  consumer accepts out_addr this cycle.
REQ-010 Port: out_addr  output  ADDR_WIDTH  binary index of the current matching row.
REQ-011 Port: out_last  output  1  current out_addr is the final match of this search.
REQ-012 Port: match_count  output  ADDR_WIDTH+1  total set bits in the accepted vector; held until the next accept.
REQ-013 Port: no_match  output  1  one-cycle pulse: accepted vector was all zeros.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and ITER.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in ITER, in_ready SHALL be 0.
REQ-016 Accept: match_valid && in_ready at edge N. The block SHALL register match_vector into a pending register, latch its popcount into match_count, and take effect at N+1.
REQ-017 Accept with a non-zero vector: the FSM SHALL enter ITER and out_valid SHALL be 1 at N+1, giving one-cycle latency.
REQ-018 Accept with a zero vector: the FSM SHALL stay in IDLE, no_match SHALL be 1 for exactly cycle N+1, and match_count SHALL be 0.
REQ-019 In ITER, out_addr SHALL be the index of the lowest set bit of the pending register (priority: lowest row wins).
REQ-020 In ITER, out_last SHALL be 1 iff exactly one bit remains in the pending register.
REQ-021 On out_valid && out_ready, the block SHALL clear the reported bit in the pending register; the next-lowest index SHALL be presented the following cycle.
REQ-022 On out_valid && out_ready && out_last, the FSM SHALL return to IDLE, with out_valid 0 and in_ready 1 the following cycle.
REQ-023 Backpressure: while out_valid && !out_ready, out_addr, out_last and the pending register SHALL hold unchanged.
REQ-024 The block SHALL ignore match_valid while in ITER; no vector is captured or queued.
REQ-025 A full vector (all CAM_DEPTH bits set) SHALL yield match_count = CAM_DEPTH and CAM_DEPTH handshakes, with addresses 0..CAM_DEPTH-1 ascending.
REQ-026 An index CAM_DEPTH-1 SHALL be encoded without truncation; match_count SHALL not wrap, since its width is ADDR_WIDTH+1.
REQ-027 With out_ready held at 1, the block SHALL emit one address per cycle with no idle bubbles between matches of one search.
REQ-028 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from match_vector to any output.

Reset
REQ-029 When rst is 1 at a clock edge, the FSM SHALL enter IDLE and the pending register and match_count SHALL clear to 0.
REQ-030 Output values while in reset and on the cycle after reset: out_valid=0, out_addr=0, out_last=0, no_match=0, in_ready=1.
REQ-031 Reset during ITER SHALL abort the iteration; remaining matches are discarded and no further out_valid occurs.
REQ-032 rst SHALL take priority over a simultaneous match_valid or out_ready handshake.

Verification
REQ-033 Single match: CAM_DEPTH=8, accept 8'b0001_0000, out_ready=1 -> next cycle out_valid=1, out_addr=4, out_last=1, match_count=1; IDLE the cycle after.
REQ-034 Multi-match with backpressure: accept 8'b1010_0110, out_ready low for 3 cycles, then high -> out_addr holds 1 during the stall, then 1,2,5,7 on consecutive cycles, out_last only with 7, match_count=4.
REQ-035 Zero vector: accept 8'h00 -> no_match=1 for exactly one cycle, out_valid stays 0, match_count=0, in_ready stays 1.
REQ-036 Full vector: accept 8'hFF, out_ready=1 -> 8 consecutive handshakes, addresses 0..7, match_count=8, out_last on 7.
REQ-037 Ignored input: during ITER, drive match_valid=1 with 8'h01 -> no effect; the original sequence completes unchanged.
REQ-038 Mid-operation reset: accept 8'hF0, consume address 4, assert rst for 1 cycle -> out_valid=0 and in_ready=1 the next cycle; a subsequent accept of 8'h02 yields out_addr=1, out_last=1.
